// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus arbiter: system address map, target select
// encoding, FSM states and requester identities.
package mem_bus_pkg;

    localparam int MAP_ADDR_W = 32;

    localparam logic [MAP_ADDR_W-1:0] INSTR_BEGIN = 32'h0040_0000;
    localparam logic [MAP_ADDR_W-1:0] INSTR_END   = 32'h0040_0FFF;
    localparam logic [MAP_ADDR_W-1:0] GPIO_BEGIN  = 32'h1001_0000;
    localparam logic [MAP_ADDR_W-1:0] GPIO_END    = 32'h1001_00FF;
    localparam logic [MAP_ADDR_W-1:0] UART_BEGIN  = 32'h1010_0000;
    localparam logic [MAP_ADDR_W-1:0] UART_END    = 32'h1010_00FF;
    localparam logic [MAP_ADDR_W-1:0] DATA_BEGIN  = 32'h1100_0000;
    localparam logic [MAP_ADDR_W-1:0] DATA_END    = 32'hFFFF_FFFF;

    // Bit position of each target inside the one-hot select.
    typedef enum logic [1:0] {
        TGT_INSTR = 2'd0,
        TGT_DATA  = 2'd1,
        TGT_GPIO  = 2'd2,
        TGT_UART  = 2'd3
    } target_e;

    typedef logic [3:0] sel_t;

    localparam sel_t SEL_INSTR = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    function automatic sel_t target_onehot(input target_e t);
        return sel_t'(4'b0001 << t);
    endfunction

    function automatic logic in_range(input logic [MAP_ADDR_W-1:0] a,
                                      input logic [MAP_ADDR_W-1:0] lo,
                                      input logic [MAP_ADDR_W-1:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/mem_addr_decoder.sv
// Combinational address decode against the system map: one-hot target select plus
// an unmapped flag when the address falls outside every region.
module mem_addr_decoder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output sel_t              sel,
    output logic              unmapped
);

    logic [MAP_ADDR_W-1:0] map_addr;

    assign map_addr = MAP_ADDR_W'(addr);

    always_comb begin
        sel = '0;
        if (in_range(map_addr, INSTR_BEGIN, INSTR_END)) begin
            sel = target_onehot(TGT_INSTR);
        end else if (in_range(map_addr, GPIO_BEGIN, GPIO_END)) begin
            sel = target_onehot(TGT_GPIO);
        end else if (in_range(map_addr, UART_BEGIN, UART_END)) begin
            sel = target_onehot(TGT_UART);
        end else if (in_range(map_addr, DATA_BEGIN, DATA_END)) begin
            sel = target_onehot(TGT_DATA);
        end
    end

    assign unmapped = (sel == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory-bus master port between the fetch and load/store ports, one
// outstanding access at a time, with address-map legality checks and a bus timeout.
//
// state | meaning
// IDLE  | nothing in flight; the arbitration winner is granted combinationally
// BUSY  | m_req held towards the decoded target, waiting for m_ready
// RESP  | rvalid pulse to the owning port with the captured read data
// ERR   | rvalid pulse with err=1 (illegal, unmapped or timed-out access)
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,

    output logic [3:0]          m_sel,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    req_id_e             owner_q;
    req_id_e             last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                m_req_q;
    sel_t                m_sel_q;
    logic                m_we_q;
    logic [DATA_W/8-1:0] m_be_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;

    logic                win_data;
    logic                take;
    logic [ADDR_W-1:0]   dec_addr;
    sel_t                dec_sel;
    logic                dec_unmapped;
    logic                legal;
    logic                busy_done;
    logic                busy_timeout;

    // On contention the port that was not granted last wins.
    always_comb begin
        win_data = 1'b0;
        if (d_req && (!i_req || last_grant_q == REQ_FETCH)) begin
            win_data = 1'b1;
        end
    end

    // Grants are held off while reset is asserted so every output reads 0 in reset.
    assign take  = rst_n && (state_q == ST_IDLE) && (i_req || d_req);
    assign i_gnt = take && !win_data;
    assign d_gnt = take && win_data;

    assign dec_addr = win_data ? d_addr : i_addr;

    mem_addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_addr_decoder (
        .addr     (dec_addr),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    assign legal = win_data ? (!dec_unmapped && !(d_we && dec_sel == SEL_INSTR))
                            : (dec_sel == SEL_INSTR);

    assign busy_done    = (state_q == ST_BUSY) && m_ready;
    assign busy_timeout = (state_q == ST_BUSY) && !m_ready && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = legal ? ST_BUSY : ST_ERR;
                end
            end
            ST_BUSY: begin
                if (busy_done) begin
                    state_d = ST_RESP;
                end else if (busy_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= REQ_FETCH;
            last_grant_q <= REQ_FETCH;
            cnt_q        <= '0;
            rdata_q      <= '0;
            m_req_q      <= 1'b0;
            m_sel_q      <= '0;
            m_we_q       <= 1'b0;
            m_be_q       <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else if (take) begin
            owner_q      <= win_data ? REQ_DATA : REQ_FETCH;
            last_grant_q <= win_data ? REQ_DATA : REQ_FETCH;
            cnt_q        <= '0;
            rdata_q      <= '0;
            if (legal) begin
                m_req_q   <= 1'b1;
                m_sel_q   <= dec_sel;
                m_we_q    <= win_data && d_we;
                m_be_q    <= win_data ? d_be : '1;
                m_addr_q  <= dec_addr;
                m_wdata_q <= win_data ? d_wdata : '0;
            end
        end else if (busy_done) begin
            // Writes complete with zero read data.
            rdata_q <= m_we_q ? '0 : m_rdata;
            cnt_q   <= '0;
            m_req_q <= 1'b0;
            m_sel_q <= '0;
        end else if (busy_timeout) begin
            cnt_q   <= '0;
            m_req_q <= 1'b0;
            m_sel_q <= '0;
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign m_req   = m_req_q;
    assign m_sel   = m_sel_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

    assign i_rvalid = (state_q == ST_RESP || state_q == ST_ERR) && owner_q == REQ_FETCH;
    assign d_rvalid = (state_q == ST_RESP || state_q == ST_ERR) && owner_q == REQ_DATA;
    assign i_err    = (state_q == ST_ERR) && owner_q == REQ_FETCH;
    assign d_err    = (state_q == ST_ERR) && owner_q == REQ_DATA;
    assign i_rdata  = (state_q == ST_RESP && owner_q == REQ_FETCH) ? rdata_q : '0;
    assign d_rdata  = (state_q == ST_RESP && owner_q == REQ_DATA)  ? rdata_q : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against an address-map and
// arbitration model held in the bench.
module tb_mem_bus_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [3:0]  m_sel;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    int vectors     = 0;
    int miscompares = 0;
    bit model_last_data = 1'b0;

    // Region table indexed by select bit: instr, data, GPIO, UART.
    logic [31:0] reg_lo [4] = '{32'h0040_0000, 32'h1100_0000, 32'h1001_0000, 32'h1010_0000};
    logic [31:0] reg_hi [4] = '{32'h0040_0FFF, 32'hFFFF_FFFF, 32'h1001_00FF, 32'h1010_00FF};

    mem_bus_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_sel    (m_sel),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input bit pd, input bit we, input logic [31:0] a,
                                  output bit legal, output logic [3:0] sel);
        sel = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (a >= reg_lo[r] && a <= reg_hi[r]) sel = 4'(1 << r);
        end
        if (pd) legal = (sel != 4'b0000) && !(we && sel == 4'b0001);
        else    legal = (sel == 4'b0001);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 3);
        case ($urandom_range(0, 5))
            0:       return reg_lo[r];
            1:       return reg_hi[r];
            2:       return reg_lo[r] + ($urandom_range(0, 255) & ~32'd3);
            3:       return reg_hi[r] + 32'd1;
            4:       return reg_lo[r] - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic expect_gnt(input bit pd);
        check("gnt_i", i_gnt, !pd);
        check("gnt_d", d_gnt, pd);
        check("gnt_no_rvalid", {i_rvalid, d_rvalid}, 0);
        check("gnt_mreq_idle", m_req, 0);
        model_last_data = pd;
    endtask

    task automatic check_resp(input bit pd, input bit err, input logic [31:0] rd);
        check("rvalid_i", i_rvalid, !pd);
        check("rvalid_d", d_rvalid, pd);
        check("resp_err", pd ? d_err : i_err, err);
        check("resp_rdata", pd ? d_rdata : i_rdata, rd);
        check("resp_no_gnt", {i_gnt, d_gnt}, 0);
    endtask

    // Runs from the cycle after the grant up to and including the response cycle.
    task automatic serve(input bit pd, input int delay);
        bit          legal;
        logic [3:0]  sel;
        logic [31:0] a, wd, rd;
        bit          we;
        logic [3:0]  be;
        int          hi;
        a  = pd ? d_addr : i_addr;
        we = pd ? d_we : 1'b0;
        be = d_be;
        wd = d_wdata;
        rd = $urandom;
        model(pd, we, a, legal, sel);
        step();
        if (pd) d_req = 1'b0; else i_req = 1'b0;
        m_ready = 1'b0;
        m_rdata = $urandom;
        #1;
        if (!legal) begin
            check("illegal_mreq", m_req, 0);
            check("illegal_msel", m_sel, 0);
            check_resp(pd, 1'b1, 32'h0);
            return;
        end
        check("m_sel", m_sel, sel);
        check("m_addr", m_addr, a);
        check("m_we", m_we, we);
        if (pd) begin
            check("m_be", m_be, be);
            check("m_wdata", m_wdata, wd);
        end
        if (delay >= TIMEOUT) begin
            hi = 0;
            while (m_req === 1'b1 && hi < TIMEOUT + 4) begin
                hi++;
                check("busy_no_gnt", {i_gnt, d_gnt}, 0);
                step();
                #1;
            end
            check("timeout_mreq_cycles", hi, TIMEOUT);
            check_resp(pd, 1'b1, 32'h0);
        end else begin
            repeat (delay) begin
                check("wait_mreq", m_req, 1);
                check("busy_no_gnt", {i_gnt, d_gnt}, 0);
                step();
                #1;
            end
            check("ready_mreq", m_req, 1);
            m_ready = 1'b1;
            m_rdata = rd;
            step();
            m_ready = 1'b0;
            m_rdata = $urandom;
            #1;
            check_resp(pd, 1'b0, we ? 32'h0 : rd);
        end
    endtask

    task automatic do_single(input bit pd, input bit we, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd, input int delay);
        step();
        if (pd) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_be = be; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
        #1;
        expect_gnt(pd);
        serve(pd, delay);
    endtask

    task automatic do_pair(input logic [31:0] fa, input bit we, input logic [31:0] da,
                           input int d0, input int d1);
        bit w;
        step();
        i_req = 1'b1; i_addr = fa;
        d_req = 1'b1; d_we = we; d_addr = da; d_be = 4'($urandom); d_wdata = $urandom;
        #1;
        w = !model_last_data;
        expect_gnt(w);
        serve(w, d0);
        step();
        #1;
        expect_gnt(!w);
        serve(!w, d1);
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_ready = 1'b0; m_rdata = '0;
        step();
        step();
        check("rst_mreq", m_req, 0);
        check("rst_msel", m_sel, 0);
        check("rst_maddr", m_addr, 0);
        check("rst_rvalid", {i_rvalid, d_rvalid, i_err, d_err}, 0);
        check("rst_gnt", {i_gnt, d_gnt}, 0);
        rst_n = 1'b1;

        // Fetch read with m_ready in the first m_req cycle.
        do_single(1'b0, 1'b0, 32'h0040_0010, 4'hF, 32'h0, 0);

        // Contention: data wins first, then fetch wins the next contention.
        step();
        i_req = 1'b1; i_addr = 32'h0040_0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004; d_be = 4'hF;
        #1;
        expect_gnt(1'b1);
        serve(1'b1, 0);
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1100_0040; d_be = 4'h3; d_wdata = 32'hCAFE_F00D;
        #1;
        expect_gnt(1'b0);
        serve(1'b0, 1);
        step();
        #1;
        expect_gnt(1'b1);
        serve(1'b1, 2);

        // Unmapped read, write to instruction memory, fetch outside instruction memory.
        do_single(1'b1, 1'b0, 32'h1000_0000, 4'hF, 32'h0, 0);
        do_single(1'b1, 1'b1, 32'h0040_0000, 4'hF, 32'h1234_5678, 0);
        do_single(1'b0, 1'b0, 32'h1100_0000, 4'hF, 32'h0, 0);

        // UART timeout followed by a normal access.
        do_single(1'b1, 1'b0, 32'h1010_0008, 4'hF, 32'h0, TIMEOUT);
        do_single(1'b1, 1'b0, 32'h1001_0000, 4'hF, 32'h0, 0);
        do_single(1'b1, 1'b0, 32'h1100_0000, 4'hF, 32'h0, TIMEOUT - 1);

        // Reset while BUSY.
        step();
        i_req = 1'b1; i_addr = 32'h0040_0100;
        #1;
        expect_gnt(1'b0);
        step();
        i_req = 1'b0;
        #1;
        check("pre_rst_mreq", m_req, 1);
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1100_0000;
        rst_n = 1'b0;
        #1;
        check("midrst_mreq", m_req, 0);
        check("midrst_msel", m_sel, 0);
        check("midrst_maddr", m_addr, 0);
        check("midrst_gnt", {i_gnt, d_gnt}, 0);
        check("midrst_rvalid", {i_rvalid, d_rvalid, i_err, d_err}, 0);
        step();
        d_req = 1'b0;
        rst_n = 1'b1;
        model_last_data = 1'b0;
        repeat (3) begin
            step();
            #1;
            check("postrst_no_rvalid", {i_rvalid, d_rvalid}, 0);
            check("postrst_mreq", m_req, 0);
        end
        do_single(1'b1, 1'b0, 32'h1100_0100, 4'hF, 32'h0, 1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int dly0, dly1;
            dly0 = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 3);
            dly1 = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0)
                do_pair(rand_addr(), 1'($urandom), rand_addr(), dly0, dly1);
            else
                do_single(1'($urandom), 1'($urandom), rand_addr(), 4'($urandom), $urandom, dly0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory-bus master port between the instruction-fetch port and the load/store data port of the core. Decodes each accepted address against the fixed system address map: instruction memory, data memory, GPIO and UART. Drives a one-hot target select with a request/ready handshake, and returns read data or an error to the requester that issued the access. Handles one outstanding transaction at a time and sits between the core and the memory/peripheral targets.

## Interface
- DATA_W, 32, data width
- ADDR_W, 32, address width
- TIMEOUT, 16, max cycles waiting for m_ready before an error response (≥2)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch accepted (1-cycle pulse)
- i_rvalid  out  1  fetch response (1-cycle pulse)
- i_rdata  out  DATA_W  fetch data, valid with i_rvalid
- i_err  out  1  fetch error, valid with i_rvalid
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/DATA_W/1  as the fetch-port equivalents
- m_sel  out  4  one-hot target: [0] instr mem, [1] data mem, [2] GPIO, [3] UART
- m_req  out  1  target request, held until m_ready
- m_we, m_be, m_addr, m_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered transaction fields
- m_ready  in  1  target completion; m_rdata valid same cycle
- m_rdata  in  DATA_W  target read data

## Operation
- Address map (inclusive ranges):
  - instr 0x0040_0000–0x0040_0FFF
  - GPIO 0x1001_0000–0x1001_00FF
  - UART 0x1010_0000–0x1010_00FF
  - data 0x1100_0000–0xFFFF_FFFF
  - everything else is unmapped.
- Access rules:
  - The fetch port may only target instr; any other region is an error.
  - The data port may read all regions.
  - A data write to the instr region is an error.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE:
  - Grant goes combinationally to the arbitration winner; i_gnt/d_gnt assert in the same cycle.
  - Transaction fields and the decoded target are captured at the clock edge.
  - Legal access → BUSY. Illegal/unmapped → ERR.
- Arbitration:
  - A single requester always wins.
  - On contention, the winner is the port not granted last. last_grant resets to fetch, so the data port wins the first contention.
- BUSY:
  - m_req=1, m_sel one-hot, m_* fields stable.
  - m_ready=1 → capture m_rdata, go to RESP.
  - The timeout counter increments each BUSY cycle. If it reaches TIMEOUT-1 without m_ready: drop m_req, go to ERR.
- RESP: pulse rvalid on the owning port with the captured rdata and err=0, then return to IDLE.
- ERR: pulse rvalid with err=1 and rdata=0, then return to IDLE.
- No new grant is issued outside IDLE. Requests stay pending and are not lost.
- Writes return rvalid (err=0) with rdata=0.
- Reset mid-transaction:
  - All state clears; no response is issued for the in-flight access.
  - The target observes m_req falling asynchronously.

## Timing
- Reset values: all outputs 0, FSM=IDLE, timeout counter 0, last_grant=fetch.
- Legal access:
  - Request and grant in cycle 0.
  - m_req from cycle 1.
  - m_ready in cycle k≥1 → rvalid in cycle k+1.
  - Minimum request-to-response latency is 2 cycles.
- Illegal access: grant in cycle 0, rvalid+err in cycle 1.
- Timeout: m_req is high for exactly TIMEOUT cycles; rvalid+err follows the cycle after m_req drops.
- Back-to-back: the next grant can occur in the cycle after rvalid, giving a 3-cycle minimum throughput per access.
- rvalid and gnt never assert in the same cycle.
- m_* outputs are registered; gnt is combinational from FSM state and the req inputs.

## Structure
- Shared package mem_bus_pkg holds:
  - the address-map BEGIN/END constants
  - the target enum/one-hot typedef
  - the FSM state enum
  - the requester-ID enum
- One sub-module, mem_addr_decoder: combinational address → one-hot select plus unmapped flag, reused by the data-port error path and the fetch-port legality check.

## Test plan
- Fetch read 0x0040_0010, m_ready in the cycle after m_req rises → i_gnt cycle 0, m_sel=0001, i_rvalid cycle 2 with i_rdata=m_rdata, i_err=0.
- i_req and d_req both high with d_addr=0x1001_0004 → d_gnt first (m_sel=0100). Fetch granted the cycle after d_rvalid. Next contention: fetch wins.
- Data read 0x1000_0000 (unmapped) → d_gnt cycle 0, d_rvalid+d_err cycle 1, m_req never asserts.
- Data write to 0x0040_0000, fetch from 0x1100_0000 → both return err=1, no target access.
- UART access, m_ready held low → m_req high exactly 16 cycles, then d_rvalid with d_err=1. The following request is served normally.
- rst_n low while in BUSY → all outputs 0 immediately, no rvalid after release. A fresh request after reset completes normally.
